// File: rtl/stream_fifo.sv
// stream_fifo -- first-word-fall-through FIFO with a sticky overflow flag.
//
// Ports:
//   clk      in   1            single clock, all state updates on rising edge
//   rstn     in   1            asynchronous active-low reset
//   wr_en    in   1            write strobe, sampled at the rising edge
//   d        in   N            write data
//   full     out  1            count == DEPTH
//   q        out  N            head-of-queue data, zero when q_valid is low
//   q_valid  out  1            count > 0
//   q_ready  in   1            consumer accepts q this cycle
//   count    out  DEPTH_LOG2+1 number of stored entries, 0..DEPTH
//   ovf      out  1            sticky: set by any write attempt while full
//
// Handshake: a pop happens at a rising edge exactly when q_valid and q_ready
// are both high; q_valid never depends on q_ready. A write is accepted at a
// rising edge exactly when wr_en is high and full is low; a write while full
// is dropped, even when a pop happens at that same edge.
module stream_fifo #(
  parameter int N          = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [N-1:0]          d,
  output logic                  full,
  output logic [N-1:0]          q,
  output logic                  q_valid,
  input  logic                  q_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [N-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count_r;
  logic                    ovf_r;
  logic                    do_wr;
  logic                    do_rd;

  // Status flags come from the registered count only.
  assign full    = (count_r == COUNT_FULL);
  assign q_valid = (count_r != '0);
  assign count   = count_r;
  assign ovf     = ovf_r;

  // Fall-through head: no read latency, forced to zero when empty so that
  // stale or never-written storage is never visible.
  assign q = q_valid ? mem[rd_ptr] : '0;

  assign do_wr = wr_en && !full;
  assign do_rd = q_valid && q_ready;

  // Storage holds no reset; entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= d;
    end
  end

  // Pointers are exactly DEPTH_LOG2 bits, so natural overflow wraps
  // DEPTH-1 -> 0 without a gap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (wr_en && full) begin
        ovf_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo -- directed self-checking bench for stream_fifo
// (N=8, DEPTH_LOG2=2). Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, well away from the next edge.
module tb_stream_fifo;

  localparam int N          = 8;
  localparam int DEPTH_LOG2 = 2;

  logic                clk;
  logic                rstn;
  logic                wr_en;
  logic [N-1:0]        d;
  logic                full;
  logic [N-1:0]        q;
  logic                q_valid;
  logic                q_ready;
  logic [DEPTH_LOG2:0] count;
  logic                ovf;

  int vectors;
  int miscompares;

  logic [N-1:0] exp_q[$];

  stream_fifo #(.N(N), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .d       (d),
    .full    (full),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .count   (count),
    .ovf     (ovf)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, " count"},   32'(count),   32'd0);
    check({tag, " q_valid"}, 32'(q_valid), 32'd0);
    check({tag, " q"},       32'(q),       32'h00);
    check({tag, " full"},    32'(full),    32'd0);
  endtask

  logic [N-1:0] exp_v;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn    = 1'b0;
    wr_en   = 1'b0;
    d       = '0;
    q_ready = 1'b0;

    // Reset state, and inputs ignored while reset is held across an edge.
    #1;
    check_empty("reset");
    check("reset ovf", 32'(ovf), 32'd0);
    wr_en   = 1'b1;
    d       = 8'hEE;
    q_ready = 1'b1;
    step();
    check("held reset count", 32'(count), 32'd0);
    check("held reset q_valid", 32'(q_valid), 32'd0);
    wr_en   = 1'b0;
    q_ready = 1'b0;
    rstn    = 1'b1;

    // Empty write: one-cycle latency to q.
    wr_en = 1'b1;
    d     = 8'h11;
    step();
    check("empty wr q",       32'(q),       32'h11);
    check("empty wr q_valid", 32'(q_valid), 32'd1);
    check("empty wr count",   32'(count),   32'd1);
    check("empty wr full",    32'(full),    32'd0);
    wr_en   = 1'b0;
    q_ready = 1'b1;
    step();
    check_empty("pop 11");
    q_ready = 1'b0;

    // Fill and overflow.
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      exp_q.push_back(8'(i));
      step();
      check("fill count", 32'(count), 32'(i));
    end
    check("fill full", 32'(full), 32'd1);
    check("fill ovf",  32'(ovf),  32'd0);
    d = 8'h05;
    step();
    check("ovf full",  32'(full),  32'd1);
    check("ovf count", 32'(count), 32'd4);
    check("ovf set",   32'(ovf),   32'd1);
    wr_en   = 1'b0;
    q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      check("drain q", 32'(q), 32'(exp_v));
      step();
    end
    check_empty("drained");
    check("ovf sticky", 32'(ovf), 32'd1);
    q_ready = 1'b0;

    // Full with simultaneous write and pop: write is dropped.
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'hA0 + 8'(i);
      step();
    end
    check("refill count", 32'(count), 32'd4);
    d       = 8'hAA;
    q_ready = 1'b1;
    step();
    check("full wr+pop count", 32'(count), 32'd3);
    check("full wr+pop full",  32'(full),  32'd0);
    check("full wr+pop ovf",   32'(ovf),   32'd1);
    check("full wr+pop head",  32'(q),     32'hA1);
    wr_en = 1'b0;
    step();
    check("after drop q", 32'(q), 32'hA2);
    step();
    check("after drop q", 32'(q), 32'hA3);
    step();
    check_empty("after drop empty");
    q_ready = 1'b0;

    // Clear ovf with an asynchronous reset pulse between edges.
    #2;
    rstn = 1'b0;
    #1;
    check("reset clears ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    step();

    // Pointer wrap: continuous streaming through all slots more than twice.
    wr_en   = 1'b1;
    q_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'h20 + 8'(i);
      step();
      check("stream q",     32'(q),     32'h20 + 32'(i));
      check("stream count", 32'(count), 32'd1);
    end
    wr_en = 1'b0;
    step();
    check_empty("stream end");
    check("stream ovf", 32'(ovf), 32'd0);

    // Pop on empty for three cycles has no effect.
    for (int i = 0; i < 3; i++) begin
      step();
      check_empty("pop empty");
    end
    q_ready = 1'b0;
    wr_en   = 1'b1;
    d       = 8'h55;
    step();
    check("post empty-pop q",     32'(q),     32'h55);
    check("post empty-pop count", 32'(count), 32'd1);

    // Build count=3 with ovf set, then reset asynchronously mid-cycle.
    for (int i = 0; i < 3; i++) begin
      d = 8'h56 + 8'(i);
      step();
    end
    d = 8'h66;
    step();
    check("pre-reset ovf", 32'(ovf), 32'd1);
    wr_en   = 1'b0;
    q_ready = 1'b1;
    step();
    check("pre-reset count", 32'(count), 32'd3);
    check("pre-reset q",     32'(q),     32'h56);
    q_ready = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    check_empty("async reset");
    check("async reset ovf", 32'(ovf), 32'd0);
    #1;
    rstn  = 1'b1;
    wr_en = 1'b1;
    d     = 8'h77;
    step();
    check("first write q",     32'(q),       32'h77);
    check("first write count", 32'(count),   32'd1);
    check("first write valid", 32'(q_valid), 32'd1);
    wr_en = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 2, giving storage depth DEPTH = 2**DEPTH_LOG2 entries; legal range is 1..8.
REQ-003 Port clk SHALL be an input of width 1: the single clock, with all state updated on its rising edge.
REQ-004 Port rstn SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 Port wr_en SHALL be an input of width 1: write strobe, sampled at the rising edge of clk (capture-enable style).
REQ-006 Port d SHALL be an input of width N: write data.
REQ-007 Port full SHALL be an output of width 1: high when count == DEPTH.
REQ-008 Port q SHALL be an output of width N: head-of-queue data.
REQ-009 Port q_valid SHALL be an output of width 1: high when count > 0.
REQ-010 Port q_ready SHALL be an input of width 1: consumer accepts q this cycle.
REQ-011 Port count SHALL be an output of width DEPTH_LOG2+1: number of stored entries, 0..DEPTH.
REQ-012 Port ovf SHALL be an output of width 1: sticky overflow flag.

Function
REQ-013 A write SHALL be accepted in a cycle iff wr_en=1 and full=0 at that rising edge; accepted data is stored at wr_ptr, and wr_ptr then increments.
REQ-014 A read (pop) SHALL occur in a cycle iff q_valid=1 and q_ready=1 at that rising edge; rd_ptr then increments.
REQ-015 q_ready while q_valid=0 SHALL have no effect.
REQ-016 wr_ptr and rd_ptr SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH with no gap (DEPTH-1 -> 0).
REQ-017 The FIFO SHALL be first-word-fall-through: q SHALL equal mem[rd_ptr] whenever q_valid=1, with no read latency.
REQ-018 q SHALL be driven to all zeros whenever q_valid=0.
REQ-019 Write-to-output latency SHALL be 1 cycle: data accepted at edge k into an empty FIFO appears on q with q_valid=1 immediately after edge k.
REQ-020 Count update per edge: write only, count+1; pop only, count-1; both or neither, count unchanged.
REQ-021 Simultaneous write and pop with 0 < count < DEPTH SHALL perform both operations, leave count unchanged, and preserve order.
REQ-022 With count=0, a write SHALL be accepted; no pop is possible in that cycle.
REQ-023 With count=DEPTH, wr_en=1 SHALL be dropped even if a pop occurs in the same cycle; the pop SHALL still complete, leaving count=DEPTH-1.
REQ-024 ovf SHALL be set at any edge where wr_en=1 and full=1, and SHALL remain 1 until reset; the dropped data SHALL not modify storage.
REQ-025 full, q_valid and count SHALL be derived only from registered state, with no combinational path from wr_en or q_ready.
REQ-026 Storage contents SHALL not require reset; correctness SHALL never depend on unwritten entries.

Reset
REQ-027 rstn=0 SHALL immediately, without waiting for clk, force: wr_ptr=0, rd_ptr=0, count=0, full=0, q_valid=0, q=0, ovf=0.
REQ-028 While rstn=0, wr_en and q_ready SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries.
REQ-030 The first write SHALL be accepted at the first rising edge after rstn deasserts.

Verification (N=8, DEPTH_LOG2=2)
REQ-031 Empty write: from reset, write 0x11 with q_ready=0 -> after the edge: q=0x11, q_valid=1, count=1, full=0.
REQ-032 Fill and overflow: write 0x01..0x04, then wr_en=1 with d=0x05 -> full=1, count=4, ovf=1, and subsequent pops return 0x01,0x02,0x03,0x04 only.
REQ-033 Full with simultaneous write and pop: count=4, wr_en=1 with d=0xAA and q_ready=1 -> 0xAA dropped, count=3, ovf=1.
REQ-034 Pointer wrap: stream 10 values 0x20..0x29 with wr_en and q_ready held at 1 -> q outputs 0x20..0x29 in order, count stays at most 1, ovf=0.
REQ-035 Pop on empty: q_ready=1 with count=0 for 3 cycles -> count=0, q=0x00, q_valid=0, pointers unchanged.
REQ-036 Async reset: with count=3, pull rstn low between clock edges -> count=0, q_valid=0, q=0x00, ovf=0 before the next edge.
